// File: rtl/clm_aes_host_ctrl.sv
// Host-side driver for the CLM AES core: assembles key/plaintext from a byte stream,
// launches the core with fresh masking randomness, and serialises the ciphertext back out.
module clm_aes_host_ctrl #(
  parameter int          d            = 4,
  parameter int          PDET_W       = 4,
  parameter int          TIMEOUT      = 1024,
  parameter logic [63:0] SEED_DEFAULT = 64'hACE1_0F0F_1234_5678
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             seed,
  input  logic                    seed_load,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_new_key,
  output logic                    s_ready,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [127:0]            core_key,
  output logic [127:0]            core_plaintext,
  output logic                    core_drdy_i,
  input  logic [127:0]            core_ciphertext,
  input  logic                    core_drdy_o,
  output logic [PDET_W-1:0]       p_det,
  output logic [23*(8+d)-1:0]     random_vect,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int EW  = 8 + d;
  localparam int RVW = 23 * EW;
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_PT, S_LAUNCH, S_WAIT, S_UNLOAD
  } state_t;

  state_t              r_state;
  logic [63:0]         r_lfsr;
  logic [63:0]         w_lfsr_nxt;
  logic [RVW-1:0]      r_rv;
  logic [127:0]        r_key;
  logic [127:0]        r_pt;
  logic [127:0]        r_ct;
  logic [3:0]          r_idx;
  logic [WDW-1:0]      r_wd;
  logic [PDET_W-1:0]   r_p_det;
  logic                r_s_ready;
  logic                r_m_valid;
  logic                r_drdy_i;
  logic                r_busy;
  logic                r_terr;

  // Fibonacci LFSR, taps 64,63,61,60, stepped once per fresh random bit.
  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < EW; i++) begin
      v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    end
    return v;
  endfunction

  always_comb begin
    w_lfsr_nxt = lfsr_adv(r_lfsr);
    if (r_state == S_IDLE && seed_load) begin
      w_lfsr_nxt = (seed == 64'd0) ? SEED_DEFAULT : seed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED_DEFAULT;
      r_rv   <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_rv   <= {w_lfsr_nxt[EW-1:0], r_rv[RVW-1:EW]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_pt      <= '0;
      r_ct      <= '0;
      r_idx     <= '0;
      r_wd      <= '0;
      r_p_det   <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_drdy_i  <= 1'b0;
      r_busy    <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_drdy_i <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_busy <= 1'b1;
            r_terr <= 1'b0;
            r_idx  <= 4'd1;
            if (s_new_key) begin
              r_key[7:0] <= s_data;
              r_state    <= S_LOAD_KEY;
            end else begin
              r_pt[7:0] <= s_data;
              r_state   <= S_LOAD_PT;
            end
          end
        end
        S_LOAD_KEY: begin
          if (s_valid) begin
            r_key[{r_idx, 3'b000} +: 8] <= s_data;
            r_idx <= r_idx + 4'd1;  // wraps to 0 for the plaintext phase
            if (r_idx == 4'd15) r_state <= S_LOAD_PT;
          end
        end
        S_LOAD_PT: begin
          if (s_valid) begin
            r_pt[{r_idx, 3'b000} +: 8] <= s_data;
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              r_state   <= S_LAUNCH;
              r_s_ready <= 1'b0;
              r_drdy_i  <= 1'b1;
              r_p_det   <= (r_lfsr[PDET_W-1:0] == '0) ? PDET_W'(1) : r_lfsr[PDET_W-1:0];
            end
          end
        end
        S_LAUNCH: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_drdy_o) begin
            r_ct      <= core_ciphertext;
            r_m_valid <= 1'b1;
            r_idx     <= '0;
            r_state   <= S_UNLOAD;
          end else if (r_wd == WDW'(TIMEOUT - 1)) begin
            r_terr    <= 1'b1;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        S_UNLOAD: begin
          if (m_ready) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              r_m_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_s_ready <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready        = r_s_ready;
  assign m_valid        = r_m_valid;
  assign m_data         = r_ct[{r_idx, 3'b000} +: 8];
  assign core_key       = r_key;
  assign core_plaintext = r_pt;
  assign core_drdy_i    = r_drdy_i;
  assign p_det          = r_p_det;
  assign random_vect    = r_rv;
  assign busy           = r_busy;
  assign timeout_err    = r_terr;

endmodule
